wheel_servo_driver: RTL and testbench

- Downstream drive stage for the line-following robot.
- Consumes the 6-bit speed command and the line-sensor vector, and produces the two continuous-rotation servo pulse trains on JD[0] (left) and JD[1] (right).
- The right wheel is mounted flipped, so its pulse width mirrors the left one about neutral.
- Sensor hits stop the wheel on the sensed side, so the robot steers back onto the line.

---
 rtl/wheel_servo_driver.sv | 106 ++++++++++
 tb/tb_wheel_servo_driver.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/wheel_servo_driver.sv
// Twin continuous-rotation servo driver: latches speed/sensor steering once per
// frame and emits mirrored left/right pulse trains with a fixed frame period.
module wheel_servo_driver #(
    parameter int unsigned FRAME_CYCLES   = 2000000,
    parameter int unsigned NEUTRAL_CYCLES = 150000,
    parameter int unsigned STEP_CYCLES    = 781,
    parameter int unsigned SPEED_W        = 6,
    parameter int unsigned SENSOR_COUNT   = 2,
    parameter int unsigned CNT_W          = 21
) (
    input  logic                    CLK100MHZ,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [SPEED_W-1:0]      speed,
    input  logic [SENSOR_COUNT-1:0] sensors,
    output logic                    wheel_l,
    output logic                    wheel_r,
    output logic                    frame_start,
    output logic                    busy,
    output logic [CNT_W-1:0]        width_l,
    output logic [CNT_W-1:0]        width_r
);

    // Wide enough that speed*STEP and NEUTRAL+offset never wrap before saturation.
    localparam int unsigned EXT_W = CNT_W + SPEED_W + 2;
    localparam logic [EXT_W-1:0] NEUTRAL_X = EXT_W'(NEUTRAL_CYCLES);
    localparam logic [EXT_W-1:0] MAX_X     = EXT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic [EXT_W-1:0] off;
    logic [EXT_W-1:0] fwd;
    logic [EXT_W-1:0] rev;
    logic [EXT_W-1:0] raw_l;
    logic [EXT_W-1:0] raw_r;
    logic [CNT_W-1:0] next_width_l;
    logic [CNT_W-1:0] next_width_r;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] max_width;
    logic             frame_end;
    logic             start;

    // A sensor hit holds that side's wheel at neutral so the robot pivots back onto the line.
    always_comb begin
        off   = EXT_W'(speed) * EXT_W'(STEP_CYCLES);
        fwd   = NEUTRAL_X + off;
        rev   = (off >= NEUTRAL_X) ? '0 : NEUTRAL_X - off;
        raw_l = sensors[SENSOR_COUNT-1] ? NEUTRAL_X : fwd;
        raw_r = sensors[0] ? NEUTRAL_X : rev;
        next_width_l = (raw_l > MAX_X) ? LAST_CNT : CNT_W'(raw_l);
        next_width_r = (raw_r > MAX_X) ? LAST_CNT : CNT_W'(raw_r);
    end

    always_comb begin
        cnt_inc   = cnt + CNT_W'(1);
        max_width = (width_l >= width_r) ? width_l : width_r;
        frame_end = (state != IDLE) && (cnt == LAST_CNT);
        start     = enable && ((state == IDLE) || frame_end);
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            wheel_l     <= 1'b0;
            wheel_r     <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            width_l     <= '0;
            width_r     <= '0;
        end else if (start) begin
            state       <= PULSE;
            cnt         <= '0;
            width_l     <= next_width_l;
            width_r     <= next_width_r;
            wheel_l     <= (next_width_l != '0);
            wheel_r     <= (next_width_r != '0);
            frame_start <= 1'b1;
            busy        <= 1'b1;
        end else if ((state == IDLE) || frame_end) begin
            state       <= IDLE;
            cnt         <= '0;
            wheel_l     <= 1'b0;
            wheel_r     <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            cnt         <= cnt_inc;
            frame_start <= 1'b0;
            wheel_l     <= (state == PULSE) && (cnt_inc < width_l);
            wheel_r     <= (state == PULSE) && (cnt_inc < width_r);
            if ((state == PULSE) && (cnt_inc >= max_width)) begin
                state <= GAP;
            end
        end
    end

endmodule

// File: tb/tb_wheel_servo_driver.sv
// Directed scoreboard bench for wheel_servo_driver on a shortened 200-cycle frame;
// a second instance with a low neutral exercises right-wheel underflow saturation.
module tb_wheel_servo_driver;

    localparam int FRAME = 200;
    localparam int N1    = 80;
    localparam int N2    = 40;
    localparam int STEP  = 1;
    localparam int CW    = 8;
    localparam int SW    = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [SW-1:0] speed;
    logic [1:0]    sensors;

    logic          wheel_l, wheel_r, frame_start, busy;
    logic [CW-1:0] width_l, width_r;
    logic          wheel_l2, wheel_r2, frame_start2, busy2;
    logic [CW-1:0] width_l2, width_r2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int l1;
        int r1;
        int l2;
        int r2;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    wheel_servo_driver #(
        .FRAME_CYCLES(FRAME), .NEUTRAL_CYCLES(N1), .STEP_CYCLES(STEP),
        .SPEED_W(SW), .SENSOR_COUNT(2), .CNT_W(CW)
    ) u_dut (
        .CLK100MHZ(clk), .rst_n(rst_n), .enable(enable), .speed(speed),
        .sensors(sensors), .wheel_l(wheel_l), .wheel_r(wheel_r),
        .frame_start(frame_start), .busy(busy), .width_l(width_l), .width_r(width_r)
    );

    wheel_servo_driver #(
        .FRAME_CYCLES(FRAME), .NEUTRAL_CYCLES(N2), .STEP_CYCLES(STEP),
        .SPEED_W(SW), .SENSOR_COUNT(2), .CNT_W(CW)
    ) u_dut_low (
        .CLK100MHZ(clk), .rst_n(rst_n), .enable(enable), .speed(speed),
        .sensors(sensors), .wheel_l(wheel_l2), .wheel_r(wheel_r2),
        .frame_start(frame_start2), .busy(busy2), .width_l(width_l2), .width_r(width_r2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int sat(input int v);
        if (v < 0) return 0;
        if (v > FRAME - 1) return FRAME - 1;
        return v;
    endfunction

    function automatic exp_t model(input int sp, input logic [1:0] se);
        exp_t e;
        int   off;
        off  = sp * STEP;
        e.l1 = sat(se[1] ? N1 : N1 + off);
        e.r1 = sat(se[0] ? N1 : N1 - off);
        e.l2 = sat(se[1] ? N2 : N2 + off);
        e.r2 = sat(se[0] ? N2 : N2 - off);
        return e;
    endfunction

    // Entered on the negedge of a frame's first cycle; at cycle chg it drives the
    // inputs for the next frame. Returns on the negedge after the frame's last cycle.
    task automatic measure_frame(input int chg, input int sp, input logic [1:0] se, input logic en);
        exp_t e;
        int   hl1 = 0, hr1 = 0, hl2 = 0, hr2 = 0;
        bit   shape_ok = 1'b1;
        bit   ctrl_ok  = 1'b1;
        check("frame_start_at_period", 32'(frame_start), 32'd1);
        check("sb_pop", 32'(sb.size() > 0), 32'd1);
        e = (sb.size() > 0) ? sb.pop_front() : '{0, 0, 0, 0};
        check("width_l", 32'(width_l), 32'(e.l1));
        check("width_r", 32'(width_r), 32'(e.r1));
        check("width_l_low", 32'(width_l2), 32'(e.l2));
        check("width_r_low", 32'(width_r2), 32'(e.r2));
        for (int i = 0; i < FRAME; i++) begin
            if (wheel_l !== 1'(i < e.l1)) shape_ok = 1'b0;
            if (wheel_r !== 1'(i < e.r1)) shape_ok = 1'b0;
            if (wheel_l2 !== 1'(i < e.l2)) shape_ok = 1'b0;
            if (wheel_r2 !== 1'(i < e.r2)) shape_ok = 1'b0;
            if (i > 0 && frame_start !== 1'b0) ctrl_ok = 1'b0;
            if (busy !== 1'b1) ctrl_ok = 1'b0;
            hl1 += int'(wheel_l);
            hr1 += int'(wheel_r);
            hl2 += int'(wheel_l2);
            hr2 += int'(wheel_r2);
            if (i == chg) begin
                speed   = SW'(sp);
                sensors = se;
                enable  = en;
                if (en) sb.push_back(model(sp, se));
            end
            @(negedge clk);
        end
        check("high_l", 32'(hl1), 32'(e.l1));
        check("high_r", 32'(hr1), 32'(e.r1));
        check("high_l_low", 32'(hl2), 32'(e.l2));
        check("high_r_low", 32'(hr2), 32'(e.r2));
        check("pulse_shape", 32'(shape_ok), 32'd1);
        check("frame_ctrl", 32'(ctrl_ok), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wheel_l"}, 32'(wheel_l), 32'd0);
        check({tag, "_wheel_r"}, 32'(wheel_r), 32'd0);
        check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_width_l"}, 32'(width_l), 32'd0);
        check({tag, "_width_r"}, 32'(width_r), 32'd0);
    endtask

    initial begin
        exp_t held;
        int   stray;

        rst_n   = 1'b0;
        enable  = 1'b0;
        speed   = '0;
        sensors = 2'b00;
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_frame_start", 32'(frame_start), 32'd0);

        // Neutral frames, then speed 32 straight ahead.
        enable = 1'b1;
        sb.push_back(model(0, 2'b00));
        @(negedge clk);
        check("first_frame_start", 32'(frame_start), 32'd1);
        measure_frame(20, 0, 2'b00, 1'b1);
        measure_frame(150, 32, 2'b00, 1'b1);

        // Speed sweep 0..60 step 4.
        for (int s = 0; s <= 60; s += 4) measure_frame(60, s, 2'b00, 1'b1);

        // Steering combinations at speed 32, inputs changed at various mid-frame points.
        measure_frame(100, 32, 2'b00, 1'b1);
        measure_frame(199, 32, 2'b01, 1'b1);
        measure_frame(5, 32, 2'b10, 1'b1);
        measure_frame(100, 32, 2'b11, 1'b1);
        measure_frame(100, 63, 2'b00, 1'b1);

        // Full speed, then reset at cycle 50 of the following frame.
        measure_frame(100, 63, 2'b00, 1'b1);
        check("reset_frame_start", 32'(frame_start), 32'd1);
        check("sb_pop_reset", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) void'(sb.pop_front());
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("midframe_reset");
        check("midframe_reset_wheel_l_low", 32'(wheel_l2), 32'd0);

        speed   = SW'(16);
        sensors = 2'b01;
        sb.push_back(model(16, 2'b01));
        rst_n = 1'b1;
        @(negedge clk);
        check("restart_frame_start", 32'(frame_start), 32'd1);

        // Drop enable at cycle 30: frame completes, then idle with widths held.
        measure_frame(30, 16, 2'b01, 1'b0);
        held = model(16, 2'b01);
        check("drop_busy", 32'(busy), 32'd0);
        check("drop_frame_start", 32'(frame_start), 32'd0);
        check("drop_wheel_l", 32'(wheel_l), 32'd0);
        check("hold_width_l", 32'(width_l), 32'(held.l1));
        check("hold_width_r", 32'(width_r), 32'(held.r1));
        stray = 0;
        for (int i = 0; i < 300; i++) begin
            stray += int'(frame_start) + int'(busy);
            @(negedge clk);
        end
        check("idle_no_frames", 32'(stray), 32'd0);

        enable = 1'b1;
        sb.push_back(model(16, 2'b01));
        @(negedge clk);
        measure_frame(50, 0, 2'b00, 1'b0);
        check("final_busy", 32'(busy), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
